// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multi-cycle MIPS core.
// Sequences the datapath through fetch/decode/execute/memory/writeback.
// Memory states stall on mem_ready unless USE_MEM_READY=0.
// Ports:
//   clk, rst          clock, async active-high reset
//   op[5:0]           opcode IR[31:26], stable from DECODE to end of instr
//   mem_ready         memory access completes this cycle
//   pcwrite..pcsrc    datapath controls, decoded from state (+ mem_ready)
//   illegal_op        pulse: unsupported opcode seen in DECODE
//   instr_done        pulse in the final cycle of each instruction
//   state[3:0]        current state, for debug
module multi_cycle_ctrl #(
  parameter logic USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   mr;

  // With wait states disabled every memory access completes in one cycle.
  assign mr    = USE_MEM_READY ? mem_ready : 1'b1;
  assign state = state_q;

  always_comb begin
    state_d    = IDLE;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mr;
        pcwrite = mr;
        state_d = mr ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is computed here, ahead of knowing the opcode.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mr ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mr;
        state_d    = mr ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = IDLE;  // unused codes 13-15 recover via IDLE
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: scoreboard bench for multi_cycle_ctrl.
// Each driven cycle pushes the expected state and control word; a negedge
// sampler pops and compares against the DUT.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, illegal_op, instr_done;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;
  exp_t sb_q[$];

  multi_cycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .illegal_op(illegal_op), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Control word order: pcwrite branch iord memwrite irwrite regdst memtoreg
  // regwrite alusrca alusrcb aluop pcsrc illegal_op instr_done
  function automatic logic [16:0] ctl_word(input logic [3:0] st, input logic m,
                                           input logic [5:0] o);
    logic pcw, br, io, mw, irw, rd, m2r, rw, sa, ill, dn;
    logic [1:0] sb, ao, ps;
    {pcw, br, io, mw, irw, rd, m2r, rw, sa, ill, dn} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin sb = 2'b01; irw = m; pcw = m; end
      4'd2:  begin
        sb = 2'b11;
        if (!(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})) begin
          ill = 1'b1; dn = 1'b1;
        end
      end
      4'd3, 4'd10: begin sa = 1'b1; sb = 2'b10; end
      4'd4:  io = 1'b1;
      4'd5:  begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
      4'd6:  begin io = 1'b1; mw = 1'b1; dn = m; end
      4'd7:  begin sa = 1'b1; ao = 2'b10; end
      4'd8:  begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
      4'd9:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; dn = 1'b1; end
      4'd11: begin rw = 1'b1; dn = 1'b1; end
      4'd12: begin ps = 2'b10; pcw = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    return {pcw, br, io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ill, dn};
  endfunction

  // One cycle of stimulus: drive after the rising edge, queue the expectation.
  task automatic step(input logic r, input logic [5:0] o, input logic m, input logic [3:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; op = o; mem_ready = m;
    e.st  = es;
    e.ctl = ctl_word(es, m, o);
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("state", {17'd0, state}, {17'd0, e.st});
      chk("ctl", {4'd0, pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
                  regwrite, alusrca, alusrcb, aluop, pcsrc, illegal_op, instr_done},
          {4'd0, e.ctl});
      chk("mw_rw_excl", {20'd0, memwrite & regwrite}, 21'd0);
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  initial begin
    // reset held 3 cycles, then a single IDLE cycle
    step(1, RT, 1, 4'd0); step(1, RT, 1, 4'd0); step(1, RT, 1, 4'd0);
    step(0, RT, 1, 4'd0);
    // R-type: FETCH DECODE EXEC ALUWB
    step(0, RT, 1, 4'd1); step(0, RT, 1, 4'd2); step(0, RT, 1, 4'd7); step(0, RT, 1, 4'd8);
    // lw with two MEMRD wait cycles: 7 cycles
    step(0, LW, 1, 4'd1); step(0, LW, 1, 4'd2); step(0, LW, 1, 4'd3);
    step(0, LW, 0, 4'd4); step(0, LW, 0, 4'd4); step(0, LW, 1, 4'd4); step(0, LW, 1, 4'd5);
    // sw with one MEMWR wait cycle
    step(0, SW, 1, 4'd1); step(0, SW, 1, 4'd2); step(0, SW, 1, 4'd3);
    step(0, SW, 0, 4'd6); step(0, SW, 1, 4'd6);
    // beq with one FETCH wait cycle
    step(0, BEQ, 0, 4'd1); step(0, BEQ, 1, 4'd1); step(0, BEQ, 1, 4'd2); step(0, BEQ, 1, 4'd9);
    // j
    step(0, JMP, 1, 4'd1); step(0, JMP, 0, 4'd2); step(0, JMP, 0, 4'd12);
    // addi
    step(0, ADDI, 1, 4'd1); step(0, ADDI, 1, 4'd2); step(0, ADDI, 1, 4'd10); step(0, ADDI, 1, 4'd11);
    // illegal opcode: pulse in DECODE, back to FETCH
    step(0, BAD, 1, 4'd1); step(0, BAD, 1, 4'd2);
    // lw interrupted by reset in MEMRD
    step(0, LW, 1, 4'd1); step(0, LW, 1, 4'd2); step(0, LW, 1, 4'd3); step(0, LW, 0, 4'd4);
    step(1, LW, 0, 4'd0);
    step(0, LW, 1, 4'd0); step(0, LW, 1, 4'd1); step(0, LW, 1, 4'd2);
    @(negedge clk);
    #1;
    chk("sb_drain", {11'd0, 10'(sb_q.size())}, 21'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
